// File: rtl/pipe_window_avg.sv
// Sliding-window sum/average over the last 2**LOG2_WIN accepted samples of F.
// Define PIPE_WINDOW_AVG_ROUND_EN to make avg round half up instead of truncating.
module pipe_window_avg #(
    parameter int N        = 10,
    parameter int LOG2_WIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [N-1:0]          F,
    input  logic                  clear,
    output logic                  out_valid,
    output logic [N-1:0]          avg,
    output logic [N+LOG2_WIN-1:0] sum,
    output logic [LOG2_WIN:0]     fill_cnt
);

    localparam int WIN = 1 << LOG2_WIN;
    localparam int SW  = N + LOG2_WIN;
    localparam logic [LOG2_WIN:0] WIN_CNT = (LOG2_WIN+1)'(WIN);
    localparam logic [SW-1:0]     HALF    = SW'(WIN / 2);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [N-1:0]          buf_mem [WIN];
    logic [LOG2_WIN-1:0]   wr_ptr;
    logic [1:0]            state;

    logic                  accept;
    logic [N-1:0]          evict;
    logic [SW-1:0]         sum_next;
    logic [LOG2_WIN:0]     fill_next;
    logic [N-1:0]          avg_next;
    logic [1:0]            state_next;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        accept     = in_valid & ~clear;
        evict      = (state == FULL) ? buf_mem[wr_ptr] : '0;
        sum_next   = sum + SW'(F) - SW'(evict);
        fill_next  = (fill_cnt == WIN_CNT) ? fill_cnt : fill_cnt + (LOG2_WIN+1)'(1);
`ifdef PIPE_WINDOW_AVG_ROUND_EN
        avg_next   = N'((sum_next + HALF) >> LOG2_WIN);
`else
        avg_next   = N'(sum_next >> LOG2_WIN);
`endif
        state_next = state;
        case (state)
            EMPTY:   state_next = (fill_next == WIN_CNT) ? FULL : FILL;
            FILL:    state_next = (fill_next == WIN_CNT) ? FULL : FILL;
            FULL:    state_next = FULL;
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: the sample buffer is reset and flushed along with the rest of the state,
    // so a restarted window never evicts a stale sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN; i++) buf_mem[i] <= '0;
            wr_ptr    <= '0;
            sum       <= '0;
            fill_cnt  <= '0;
            avg       <= '0;
            out_valid <= 1'b0;
            state     <= EMPTY;
        end else if (clear) begin
            for (int i = 0; i < WIN; i++) buf_mem[i] <= '0;
            wr_ptr    <= '0;
            sum       <= '0;
            fill_cnt  <= '0;
            avg       <= '0;
            out_valid <= 1'b0;
            state     <= EMPTY;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                buf_mem[wr_ptr] <= F;
                wr_ptr          <= wr_ptr + LOG2_WIN'(1);
                sum             <= sum_next;
                avg             <= avg_next;
                fill_cnt        <= fill_next;
                state           <= state_next;
                out_valid       <= (fill_next == WIN_CNT);
            end
        end
    end

endmodule
